// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file family (ARF, IR and the parameterised GP file):
// FunSel operation encodings and sizing limits.
package regfile_pkg;

  localparam logic [1:0] FUN_DEC  = 2'b00;
  localparam logic [1:0] FUN_INC  = 2'b01;
  localparam logic [1:0] FUN_LOAD = 2'b10;
  localparam logic [1:0] FUN_CLR  = 2'b11;

  localparam int MAX_REGS  = 16;
  localparam int MIN_WIDTH = 2;

endpackage

// File: rtl/param_reg_file_if.sv
// Control/data bundle of param_reg_file: shared FunSel, active-low register selects,
// load data, two read-port indices and their data, plus the per-register wrap flags.
interface param_reg_file_if #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4
);
  localparam int SEL_W = $clog2(NUM_REGS);

  logic [1:0]          FunSel;
  logic [NUM_REGS-1:0] RegSel;
  logic [WIDTH-1:0]    I;
  logic [SEL_W-1:0]    OutASel;
  logic [SEL_W-1:0]    OutBSel;
  logic [WIDTH-1:0]    OutA;
  logic [WIDTH-1:0]    OutB;
  logic [NUM_REGS-1:0] Wrap;

  modport master (
    output FunSel, RegSel, I, OutASel, OutBSel,
    input  OutA, OutB, Wrap
  );

  modport slave (
    input  FunSel, RegSel, I, OutASel, OutBSel,
    output OutA, OutB, Wrap
  );
endinterface

// File: rtl/nbit_counter_reg.sv
// One register of the file: dec / inc / load / clear under a shared FunSel,
// with a sticky wrap flag set on modulo roll-over.
module nbit_counter_reg
  import regfile_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int RESET_VALUE = 0
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             En,
  input  logic [1:0]       FunSel,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; a blocking '=' here would create ordering-dependent races.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Q    <= RST_Q;
      Wrap <= 1'b0;
    end else if (En) begin
      case (FunSel)
        FUN_DEC: begin
          Q <= Q - ONE;
          if (Q == '0) Wrap <= 1'b1;
        end
        FUN_INC: begin
          Q <= Q + ONE;
          if (&Q) Wrap <= 1'b1;
        end
        FUN_LOAD: begin
          Q    <= I;
          Wrap <= 1'b0;
        end
        default: begin
          Q    <= '0;
          Wrap <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/param_reg_file.sv
// NUM_REGS x WIDTH general-purpose register file with two combinational read ports.
// Optional same-cycle load bypass on the read ports when REGFILE_BYPASS_EN is defined.
module param_reg_file
  import regfile_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NUM_REGS    = 4,
  parameter int RESET_VALUE = 0
) (
  input logic              Clock,
  input logic              Reset_n,
  param_reg_file_if.slave  bus
);

  localparam int SEL_W = $clog2(NUM_REGS);
  localparam int DEPTH = 2 ** SEL_W;

  logic [WIDTH-1:0]    q [NUM_REGS];
  logic [NUM_REGS-1:0] wrap;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    nbit_counter_reg #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_reg (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .En      (~bus.RegSel[k]),
      .FunSel  (bus.FunSel),
      .I       (bus.I),
      .Q       (q[k]),
      .Wrap    (wrap[k])
    );
  end

  assign bus.Wrap = wrap;

  // Pad to a power-of-two table so indices past NUM_REGS read as zero.
  logic [WIDTH-1:0] q_pad [DEPTH];
`ifdef REGFILE_BYPASS_EN
  logic [DEPTH-1:0] load_pad;
`endif

  for (genvar j = 0; j < DEPTH; j++) begin : g_pad
    if (j < NUM_REGS) begin : g_live
      assign q_pad[j] = q[j];
`ifdef REGFILE_BYPASS_EN
      assign load_pad[j] = ~bus.RegSel[j] & (bus.FunSel == FUN_LOAD);
`endif
    end else begin : g_hole
      assign q_pad[j] = '0;
`ifdef REGFILE_BYPASS_EN
      assign load_pad[j] = 1'b0;
`endif
    end
  end

  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;

  // NOTE: each always_comb output is assigned a default before any condition,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    out_a = q_pad[bus.OutASel];
    out_b = q_pad[bus.OutBSel];
`ifdef REGFILE_BYPASS_EN
    if (load_pad[bus.OutASel]) out_a = bus.I;
    if (load_pad[bus.OutBSel]) out_b = bus.I;
`endif
  end

  assign bus.OutA = out_a;
  assign bus.OutB = out_b;

endmodule

// File: tb/tb_param_reg_file.sv
// Directed bench for param_reg_file: default 4x8 file, a 3-deep file and a 16-bit file.
// Expected values are hand-derived constants; REGFILE_BYPASS_EN selects the bypass expectation.
module tb_param_reg_file;
  import regfile_pkg::*;

  logic Clock;
  logic Reset_n;

  int n_checks = 0;
  int n_fail   = 0;

  param_reg_file_if #(.WIDTH(8),  .NUM_REGS(4)) b4 ();
  param_reg_file_if #(.WIDTH(8),  .NUM_REGS(3)) b3 ();
  param_reg_file_if #(.WIDTH(16), .NUM_REGS(4)) b16 ();

  param_reg_file #(.WIDTH(8), .NUM_REGS(4), .RESET_VALUE(0)) dut (
    .Clock (Clock), .Reset_n (Reset_n), .bus (b4.slave)
  );
  param_reg_file #(.WIDTH(8), .NUM_REGS(3), .RESET_VALUE(0)) dut3 (
    .Clock (Clock), .Reset_n (Reset_n), .bus (b3.slave)
  );
  param_reg_file #(.WIDTH(16), .NUM_REGS(4), .RESET_VALUE(16'h1234)) dut16 (
    .Clock (Clock), .Reset_n (Reset_n), .bus (b16.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic op(input logic [3:0] sel, input logic [1:0] fs, input logic [7:0] d);
    b4.RegSel = sel;
    b4.FunSel = fs;
    b4.I      = d;
  endtask

  task automatic rd(input logic [1:0] a, input logic [1:0] b);
    b4.RegSel  = 4'b1111;
    b4.OutASel = a;
    b4.OutBSel = b;
    #1;
  endtask

  logic [7:0] byp_exp;

  initial begin
    Reset_n = 1'b0;
    op(4'b1111, FUN_DEC, 8'h00);
    b4.OutASel = 2'd0;  b4.OutBSel = 2'd0;
    b3.RegSel  = 3'b111; b3.FunSel = FUN_DEC; b3.I = 8'h00;
    b3.OutASel = 2'd0;  b3.OutBSel = 2'd0;
    b16.RegSel = 4'b1111; b16.FunSel = FUN_DEC; b16.I = 16'h0000;
    b16.OutASel = 2'd0; b16.OutBSel = 2'd0;

    #12;
    check("reset_outa",       b4.OutA,  8'h00);
    check("reset_wrap",       b4.Wrap,  4'b0000);
    check("reset_dut3_wrap",  b3.Wrap,  3'b000);
    check("reset_w16_value",  b16.OutA, 16'h1234);
    @(negedge Clock) Reset_n = 1'b1;

    // Reset mid-operation
    op(4'b0111, FUN_DEC, 8'h00); step();
    rd(2'd3, 2'd0);
    check("dec_r3_wrap_val",  b4.OutA, 8'hFF);
    check("dec_r3_wrap_flag", b4.Wrap, 4'b1000);
    op(4'b1110, FUN_LOAD, 8'h5A); step();
    rd(2'd0, 2'd3);
    check("load_r0",          b4.OutA, 8'h5A);
    check("load_keeps_wrap3", b4.Wrap, 4'b1000);
    Reset_n = 1'b0;
    #1;
    check("async_rst_outa",   b4.OutA, 8'h00);
    check("async_rst_outb",   b4.OutB, 8'h00);
    check("async_rst_wrap",   b4.Wrap, 4'b0000);
    @(negedge Clock) Reset_n = 1'b1;

    // Load and dual read
    for (int i = 0; i < 4; i++) begin
      op(4'(~(4'b0001 << i)), FUN_LOAD, 8'(8'h11 * (i + 1)));
      step();
    end
    rd(2'd2, 2'd3);
    check("dual_read_a",      b4.OutA, 8'h33);
    check("dual_read_b",      b4.OutB, 8'h44);
    rd(2'd1, 2'd1);
    check("same_reg_a",       b4.OutA, 8'h22);
    check("same_reg_b",       b4.OutB, 8'h22);

    // Wrap on increment, sticky, cleared by clear and by load
    op(4'b1101, FUN_LOAD, 8'hFF); step();
    op(4'b1101, FUN_INC,  8'h00); step();
    rd(2'd1, 2'd0);
    check("inc_wrap_val",     b4.OutA, 8'h00);
    check("inc_wrap_flag",    b4.Wrap, 4'b0010);
    op(4'b1101, FUN_INC,  8'h00); step();
    rd(2'd1, 2'd0);
    check("inc_again_val",    b4.OutA, 8'h01);
    check("wrap_sticky",      b4.Wrap, 4'b0010);
    op(4'b1111, FUN_INC,  8'h00); step();
    rd(2'd1, 2'd0);
    check("noop_r1_hold",     b4.OutA, 8'h01);
    check("noop_r0_hold",     b4.OutB, 8'h11);
    op(4'b1101, FUN_CLR,  8'h00); step();
    rd(2'd1, 2'd0);
    check("clr_val",          b4.OutA, 8'h00);
    check("clr_wrap",         b4.Wrap, 4'b0000);
    op(4'b1101, FUN_DEC,  8'h00); step();
    op(4'b1101, FUN_LOAD, 8'h07); step();
    rd(2'd1, 2'd0);
    check("load_after_wrap",  b4.OutA, 8'h07);
    check("load_clears_wrap", b4.Wrap, 4'b0000);

    // Wrap on decrement with multi-select
    op(4'b0000, FUN_CLR, 8'h00); step();
    op(4'b0101, FUN_DEC, 8'h00); step();
    rd(2'd1, 2'd3);
    check("multi_wrap_flags", b4.Wrap, 4'b1010);
    check("multi_dec_r1",     b4.OutA, 8'hFF);
    check("multi_dec_r3",     b4.OutB, 8'hFF);
    rd(2'd0, 2'd2);
    check("unsel_r0",         b4.OutA, 8'h00);
    check("unsel_r2",         b4.OutB, 8'h00);
    op(4'b0101, FUN_DEC, 8'h00); step();
    op(4'b1110, FUN_INC, 8'h00); step();
    rd(2'd3, 2'd0);
    check("dec_no_wrap_r3",   b4.OutA, 8'hFE);
    check("inc_r0",           b4.OutB, 8'h01);
    check("wraps_after_more", b4.Wrap, 4'b1010);

    // Bypass (or not) of a pending load
`ifdef REGFILE_BYPASS_EN
    byp_exp = 8'hC3;
`else
    byp_exp = 8'h00;
`endif
    b4.OutASel = 2'd2; b4.OutBSel = 2'd0;
    op(4'b1011, FUN_LOAD, 8'hC3);
    #1;
    check("pre_edge_load_a",  b4.OutA, byp_exp);
    check("pre_edge_other_b", b4.OutB, 8'h01);
    step();
    rd(2'd2, 2'd0);
    check("post_edge_load",   b4.OutA, 8'hC3);
    op(4'b1011, FUN_INC, 8'h00);
    #1;
    check("pre_edge_inc_old", b4.OutA, 8'hC3);
    step();
    rd(2'd2, 2'd0);
    check("post_edge_inc",    b4.OutA, 8'hC4);

    // Odd depth: out-of-range index reads zero
    b3.RegSel = 3'b011; b3.FunSel = FUN_LOAD; b3.I = 8'h05;
    step();
    b3.RegSel = 3'b111; b3.OutASel = 2'd3; b3.OutBSel = 2'd2;
    #1;
    check("odd_oob_zero",     b3.OutA, 8'h00);
    check("odd_r2",           b3.OutB, 8'h05);

    // 16-bit width wrap
    b16.RegSel = 4'b1110; b16.FunSel = FUN_LOAD; b16.I = 16'hFFFF;
    step();
    b16.FunSel = FUN_INC;
    step();
    b16.RegSel = 4'b1111; b16.OutASel = 2'd0; b16.OutBSel = 2'd1;
    #1;
    check("w16_inc_wrap_val", b16.OutA, 16'h0000);
    check("w16_wrap_flag",    b16.Wrap, 4'b0001);
    check("w16_r1_reset_val", b16.OutB, 16'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
